// File: rtl/dmem_pkg.sv
// Shared types for the DMEM responder: access size encoding, wait-state FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   size_e          - access width decoded from the byte / half-word qualifiers
//   state_e         - wait-state FSM states
//   MAX_WAIT_STATES - largest wait-state count the 4-bit counter can express
//   decode_size     - qualifier pair -> size_e, byte wins over half-word
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_WORD = 2'd0,
        SZ_HALF = 2'd1,
        SZ_BYTE = 2'd2
    } size_e;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    localparam int MAX_WAIT_STATES = 15;

    function automatic size_e decode_size(input logic byte_access, input logic half_word);
        size_e sz;
        if (byte_access) begin
            sz = SZ_BYTE;
        end else if (half_word) begin
            sz = SZ_HALF;
        end else begin
            sz = SZ_WORD;
        end
        return sz;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Big-endian lane steering: load extraction/extension, store write-merge, alignment check.
// Latency: purely combinational.
// Backpressure: none; evaluated whenever the top presents an access.
//
// Ports:
//   offset      - byte offset within the word (numeric, 0 = bits [0:7])
//   size        - access width
//   sign_extend - sign-extend sub-word loads, else zero-extend
//   rd_word     - current contents of the addressed RAM word
//   st_data     - store data, sub-word values right-justified
//   ld_data     - right-justified, extended load result (0 when misaligned)
//   wr_word     - rd_word with only the addressed lane(s) replaced
//   misaligned  - access violates its natural alignment
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  offset,
    input  size_e       size,
    input  logic        sign_extend,
    input  logic [0:31] rd_word,
    input  logic [0:31] st_data,
    output logic [0:31] ld_data,
    output logic [0:31] wr_word,
    output logic        misaligned
);

    // Vectors are ascending (bit 0 = MSB), so base 8*offset lands on the
    // big-endian byte lane directly: offset 0 -> [0:7], offset 3 -> [24:31].
    logic [4:0]  byte_base;
    logic [4:0]  half_base;
    logic [0:7]  byte_lane;
    logic [0:15] half_lane;

    assign byte_base = {offset, 3'b000};
    assign half_base = {offset[1], 4'b0000};

    always_comb begin
        ld_data    = '0;
        wr_word    = rd_word;
        misaligned = 1'b0;
        byte_lane  = '0;
        half_lane  = '0;

        case (size)
            SZ_BYTE: begin
                byte_lane = rd_word[byte_base +: 8];
                // lane bit 0 is the lane MSB
                ld_data   = {{24{sign_extend & byte_lane[0]}}, byte_lane};
                wr_word[byte_base +: 8] = st_data[24:31];
            end
            SZ_HALF: begin
                misaligned = offset[0];
                if (!offset[0]) begin
                    half_lane = rd_word[half_base +: 16];
                    ld_data   = {{16{sign_extend & half_lane[0]}}, half_lane};
                    wr_word[half_base +: 16] = st_data[16:31];
                end
            end
            default: begin
                // word loads ignore sign_extend
                misaligned = (offset != 2'd0);
                if (offset == 2'd0) begin
                    ld_data = rd_word;
                    wr_word = st_data;
                end
            end
        endcase

        // a misaligned store leaves the word untouched
        if (misaligned) begin
            wr_word = rd_word;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// DMEM responder: word-organised big-endian RAM with lane select/merge and programmable wait states.
// Latency: completes WAIT_STATES cycles after req is first seen (same cycle when WAIT_STATES=0).
// Backpressure: stall held high while the access is pending; requester keeps req and qualifiers stable.
//
// Ports:
//   clock, reset           - system clock, synchronous active-high reset
//   req                    - access request, held with qualifiers until stall is low
//   addr                   - byte address, bit 31 is LSB; bits above the RAM size are ignored
//   write_enable           - 1 = store, 0 = load
//   byte_access, half_word - access width qualifiers (byte wins)
//   sign_extend            - sign-extend sub-word loads
//   data_in                - store data, sub-word values right-justified
//   data_out               - load data in the completion cycle, else 0
//   stall                  - access pending, pipeline must freeze
//   misaligned             - alignment error on the completing access
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS),
    parameter int WAIT_STATES = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic [0:31] addr,
    input  logic        write_enable,
    input  logic        byte_access,
    input  logic        half_word,
    input  logic        sign_extend,
    input  logic [0:31] data_in,
    output logic [0:31] data_out,
    output logic        stall,
    output logic        misaligned
);

    // Out-of-range wait-state counts saturate to what the 4-bit counter can hold.
    localparam int WS_EFF = (WAIT_STATES > MAX_WAIT_STATES) ? MAX_WAIT_STATES :
                            (WAIT_STATES < 0)               ? 0 : WAIT_STATES;
    localparam bit          NO_WAIT  = (WS_EFF == 0);
    // The request cycle itself is the first stall cycle, so the counter is
    // loaded with one less than the wait-state count.
    localparam logic [3:0]  CNT_LOAD = NO_WAIT ? 4'd0 : 4'(WS_EFF - 1);

    // ---------------------------------------------------------------
    // Address decode
    // ---------------------------------------------------------------
    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        lane_off;
    logic              unused_addr_hi;

    assign word_idx       = addr[30-ADDR_W:29];
    assign lane_off       = {addr[30], addr[31]};
    // upper address bits wrap the RAM and are intentionally ignored
    assign unused_addr_hi = ^addr[0:29-ADDR_W];

    // ---------------------------------------------------------------
    // RAM and lane steering
    // ---------------------------------------------------------------
    logic [0:31] mem [DEPTH_WORDS];
    logic [0:31] rd_word;
    logic [0:31] ld_data;
    logic [0:31] wr_word;
    logic        lane_misaligned;
    size_e       acc_size;

    assign rd_word  = mem[word_idx];
    assign acc_size = decode_size(byte_access, half_word);

    dmem_lane_align u_lane_align (
        .offset      (lane_off),
        .size        (acc_size),
        .sign_extend (sign_extend),
        .rd_word     (rd_word),
        .st_data     (data_in),
        .ld_data     (ld_data),
        .wr_word     (wr_word),
        .misaligned  (lane_misaligned)
    );

    // ---------------------------------------------------------------
    // Wait-state FSM
    // ---------------------------------------------------------------
    state_e     state;
    state_e     state_next;
    logic [3:0] cnt;
    logic [3:0] cnt_next;
    logic       stall_raw;
    logic       complete_raw;
    logic       complete;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        stall_raw    = 1'b0;
        complete_raw = 1'b0;

        case (state)
            IDLE: begin
                if (req) begin
                    if (NO_WAIT) begin
                        complete_raw = 1'b1;
                    end else begin
                        stall_raw  = 1'b1;
                        cnt_next   = CNT_LOAD;
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    // requester withdrew: abandon the access, nothing is written
                    state_next = IDLE;
                    cnt_next   = 4'd0;
                end else if (cnt != 4'd0) begin
                    stall_raw = 1'b1;
                    cnt_next  = cnt - 4'd1;
                end else begin
                    // completion cycle; a request still present next cycle
                    // is a new access and starts a fresh wait from IDLE
                    complete_raw = 1'b1;
                    state_next   = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    // Reset masks the outputs and the write in the same cycle, so an access
    // caught by reset is dropped rather than committed.
    assign complete   = complete_raw & ~reset;
    assign stall      = stall_raw & ~reset;
    assign misaligned = complete & lane_misaligned;
    assign data_out   = complete ? ld_data : '0;

    // Read-modify-write commit on the edge that ends the completion cycle.
    // Not reset: RAM contents survive reset.
    always_ff @(posedge clock) begin
        if (complete && write_enable && !lane_misaligned) begin
            mem[word_idx] <= wr_word;
        end
    end

endmodule
